// File: rtl/subpel_pkg.sv
// Shared constants and FSM encoding for the subpixel row sequencer.
package subpel_pkg;
  localparam int PIX_W    = 8;
  localparam int ROW_W    = 15 * PIX_W;
  localparam int NUM_ROWS = 15;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DP, DONE} state_t;
endpackage

// File: rtl/subpel_row_fifo2.sv
// Two-entry in-order FIFO holding {row index, row pixels} between memory and datapath.
module subpel_row_fifo2
  import subpel_pkg::*;
#(
  parameter int W = ROW_W + IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [1:0]   occ,
  output logic         head_vld,
  output logic [W-1:0] head_data
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  // storage is reset too, so head_data reads as zero straight out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_vld  = (occ != 2'd0);
  assign head_data = mem[rd_ptr];
endmodule

// File: rtl/subpel_row_sequencer.sv
// Fetches one block of pixel rows from row memory and streams them to the
// subpixel datapath under valid/ready, then waits for the datapath to finish.
module subpel_row_sequencer
  import subpel_pkg::*;
#(
  parameter int ROW_W    = subpel_pkg::ROW_W,
  parameter int NUM_ROWS = subpel_pkg::NUM_ROWS,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ROW_W-1:0]  mem_rd_data,
  output logic              dp_start,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ROW_W-1:0]  row_data,
  output logic [3:0]        row_idx,
  output logic              row_last,
  input  logic              dp_done
);
  state_t                   state, state_nx;
  logic [ADDR_W-1:0]        base_q;
  logic [IDX_W-1:0]         issued, rd_idx;
  logic                     rd_pending, first_q, err_q;
  logic                     pop, push, flush, issue, accept_start;
  logic [1:0]               occ;
  logic [IDX_W+ROW_W-1:0]   head;

  assign accept_start = (state == IDLE) && start && !abort;
  assign pop          = row_valid && row_ready;
  // a row returning in the abort cycle is dropped together with the flush
  assign push         = rd_pending && !abort;
  assign flush        = abort;

  // keep reads-in-flight plus buffered rows within the two FIFO slots
  assign issue = (state == FETCH) && !abort &&
                 (int'(issued) < NUM_ROWS) &&
                 (({1'b0, occ} + {2'b0, rd_pending} - {2'b0, pop}) < 3'd2);

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? (base_q + ADDR_W'(issued)) : '0;

  subpel_row_fifo2 #(.W(IDX_W + ROW_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({rd_idx, mem_rd_data}),
    .occ       (occ),
    .head_vld  (row_valid),
    .head_data (head)
  );

  assign row_data = head[ROW_W-1:0];
  assign row_idx  = head[IDX_W+ROW_W-1:ROW_W];
  assign row_last = row_valid && (row_idx == IDX_W'(NUM_ROWS - 1));
  assign err      = err_q;
  assign dp_start = first_q;

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      IDLE:    if (accept_start) state_nx = FETCH;
      FETCH:   if (abort) state_nx = IDLE;
               else if (pop && row_last) state_nx = WAIT_DP;
      WAIT_DP: if (abort) state_nx = IDLE;
               else if (dp_done) state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        done     = !abort;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      issued     <= '0;
      rd_idx     <= '0;
      rd_pending <= 1'b0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      first_q    <= accept_start;
      rd_pending <= issue;
      if (issue) rd_idx <= issued;
      if (accept_start) begin
        base_q <= base_addr;
        issued <= '0;
        err_q  <= 1'b0;
      end else begin
        if (issue) issued <= issued + 1'b1;
        // a completion flag while rows are still streaming is a protocol error
        if (state == FETCH && dp_done) err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_subpel_row_sequencer.sv
// Directed bench for subpel_row_sequencer with a transaction-level block model.
module tb_subpel_row_sequencer;
  localparam int ROW_W = 120, NUM_ROWS = 15, ADDR_W = 8;

  logic clk = 0, rst = 0, start = 0, abort = 0, row_ready = 0, dp_done = 0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic busy, done, err, mem_rd_en, dp_start, row_valid, row_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0] mem_rd_data = '0;
  logic [ROW_W-1:0] row_data;
  logic [3:0] row_idx;

  int tests = 0, fails = 0, cyc = 0;

  bit active = 0, stalled = 0, hs_done = 0;
  logic [7:0] m_base;
  int nreads, naccept, start_cyc, last_hs_cyc, first_rd_rel, row0_rel, last_rel;
  int done_rel, done_cnt, stall_cnt, rel;
  logic [7:0] addr_log [16];
  logic [ROW_W-1:0] hs_log [16];
  logic [ROW_W-1:0] stall_data;
  logic [3:0] stall_idx;
  bit pat [4] = '{1, 0, 0, 1};

  subpel_row_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
    .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .dp_start(dp_start), .row_valid(row_valid),
    .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx),
    .row_last(row_last), .dp_done(dp_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ROW_W-1:0] row_of(input logic [7:0] a);
    return {15{a}};
  endfunction

  // row memory: row at address a is {15{a}}; off-cycle data is poisoned
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? row_of(mem_addr) : {15{8'hEE}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // block model: every read, handshake and completion checked against the rules
  always @(negedge clk) begin
    if (rst) begin
      active = 0; stalled = 0; hs_done = 0;
    end else begin
      rel = cyc - start_cyc;
      if (active && rel == 1) begin
        chk("dp_start_first", dp_start, 1);
        chk("err_cleared", err, 0);
      end else if (dp_start) chk("dp_start_stray", 0, 1);
      if (mem_rd_en) begin
        chk("rd_when_active", active && nreads < NUM_ROWS && !abort, 1);
        chk("rd_addr", mem_addr, 8'(m_base + nreads));
        if (nreads < 16) addr_log[nreads] = mem_addr;
        if (nreads == 0) first_rd_rel = rel;
        nreads++;
      end
      if (row_valid) begin
        chk("valid_when_active", active, 1);
        if (stalled) begin
          chk("stall_data", row_data, stall_data);
          chk("stall_idx", row_idx, stall_idx);
        end
        if (row_ready) begin
          chk("hs_idx", row_idx, naccept);
          chk("hs_data", row_data, row_of(8'(m_base + naccept)));
          chk("hs_last", row_last, naccept == NUM_ROWS - 1);
          if (naccept < 16) hs_log[naccept] = row_data;
          if (naccept == 0) row0_rel = rel;
          if (naccept == NUM_ROWS - 1) begin
            hs_done = 1; last_hs_cyc = cyc; last_rel = rel;
          end
          naccept++;
          stalled = 0;
        end else begin
          if (stalled) stall_cnt++;
          stalled = 1; stall_data = row_data; stall_idx = row_idx;
        end
      end else begin
        if (stalled) chk("stall_dropped", 0, 1);
        chk("last_without_valid", row_last, 0);
        stalled = 0;
      end
      if (active) chk("outstanding", (nreads - naccept) <= 2, 1);
      if (done) begin
        chk("done_after_all_rows", naccept, NUM_ROWS);
        done_cnt++; done_rel = rel;
      end
      if (abort && busy) begin
        active = 0; stalled = 0;
      end
      if (start && !abort && !busy) begin
        active = 1; m_base = base_addr; nreads = 0; naccept = 0; hs_done = 0;
        start_cyc = cyc; done_cnt = 0; first_rd_rel = -1; row0_rel = -1;
        last_rel = -1; done_rel = -1;
      end
    end
  end

  task automatic kick(input logic [7:0] b);
    @(posedge clk); #1;
    base_addr = b; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_block(input logic [7:0] b, input bit bp, input int dp_delay,
                           input int err_rel, input int exp_done_rel, input bit exp_err);
    int t;
    kick(b);
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      row_ready = bp ? pat[(cyc - start_cyc) % 4] : 1'b1;
      dp_done = (hs_done && cyc == last_hs_cyc + dp_delay) ||
                (err_rel > 0 && cyc - start_cyc == err_rel);
      @(posedge clk); #1;
      t++;
    end
    dp_done = 0; row_ready = 1;
    chk("block_done_seen", done_cnt, 1);
    chk("reads_total", nreads, NUM_ROWS);
    chk("handshakes_total", naccept, NUM_ROWS);
    chk("err_at_end", err, exp_err);
    if (exp_done_rel > 0) begin
      chk("first_rd_cycle", first_rd_rel, 1);
      chk("row0_cycle", row0_rel, 3);
      chk("row14_cycle", last_rel, 17);
      chk("done_cycle", done_rel, exp_done_rel);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt, 1);
    chk("idle_after_block", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1 rst = 1;
    #3;
    chk("reset_flags", {busy, done, err, mem_rd_en, dp_start, row_valid, row_last}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_data", row_data, 0);
    chk("reset_idx", row_idx, 0);
    @(posedge clk); #1 rst = 0;

    // full rate from address 0
    run_block(8'h00, 0, 2, 0, 20, 0);
    chk("s1_row0_data", hs_log[0], row_of(8'h00));
    chk("s1_row14_data", hs_log[14], {15{8'h0E}});

    // backpressure 1,0,0,1
    stall_cnt = 0;
    run_block(8'h50, 1, 2, 0, -1, 0);
    chk("bp_stalls_seen", stall_cnt > 0, 1);

    // address wrap
    run_block(8'hF8, 0, 2, 0, 20, 0);
    chk("wrap_addr0", addr_log[0], 8'hF8);
    chk("wrap_addr8", addr_log[8], 8'h00);
    chk("wrap_addr14", addr_log[14], 8'h06);
    chk("wrap_row8_data", hs_log[8], {15{8'h00}});

    // abort after row 5 accepted, read still in flight
    row_ready = 1;
    kick(8'h20);
    t = 0;
    while (naccept < 6 && t < 60) begin @(posedge clk); #1; t++; end
    chk("abort_setup", naccept, 6);
    abort = 1; row_ready = 0;
    @(negedge clk);
    chk("abort_cycle_busy", busy, 1);
    @(posedge clk); #1 abort = 0; row_ready = 1;
    @(negedge clk);
    chk("abort_idle", {busy, row_valid, done}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_stays_idle", busy, 0);
    run_block(8'h10, 0, 1, 0, 19, 0);
    chk("post_abort_row0", hs_log[0], {15{8'h10}});

    // early dp_done during FETCH
    run_block(8'h40, 0, 1, 8, 19, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held", err, 1);
    run_block(8'h60, 0, 1, 0, 19, 0);

    // asynchronous reset in the middle of FETCH
    row_ready = 1;
    kick(8'h30);
    repeat (6) @(posedge clk);
    #2;
    chk("midrst_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("midrst_flags", {busy, done, err, mem_rd_en, dp_start, row_valid, row_last}, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_data", row_data, 0);
    chk("midrst_idx", row_idx, 0);
    @(posedge clk); #1 rst = 0;
    run_block(8'h00, 0, 2, 0, 20, 0);
    chk("midrst_row14_data", hs_log[14], {15{8'h0E}});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
